// File: rtl/regfile_exec_ctrl_if.sv
// Bundles the instruction handshake and the register-file port of the
// execution controller. master = controller side, slave = source/regfile side.
// Signals: instr_valid/instr_ready/instr (handshake), A/B read ports, D write port.
interface regfile_exec_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [1:0] A_addr;
  logic [1:0] B_addr;
  logic [3:0] A_data;
  logic [3:0] B_data;
  logic [1:0] D_addr;
  logic [3:0] D_data;
  logic       nWE;

  modport master (
    input  instr_valid, instr, A_data, B_data,
    output instr_ready, A_addr, B_addr, D_addr, D_data, nWE
  );

  modport slave (
    output instr_valid, instr, A_data, B_data,
    input  instr_ready, A_addr, B_addr, D_addr, D_data, nWE
  );
endinterface

// File: rtl/regfile_exec_ctrl.sv
// Execution controller: accepts an 8-bit instruction, reads two operands from
// the 4x4 register file, computes ADD/SUB/AND/LDI and writes the result back.
// Latency: accept at E0, READ/EXEC/WRITE in cycles 1-3, regfile written at E3.
// Backpressure: instr_ready high only in IDLE, so one instruction per 4 cycles.
// Ports: clk, nRST (async active-low), bus (instr handshake + regfile ports),
//        done (retire pulse), carry/zero (flags from the last EXEC).
module regfile_exec_ctrl (
  input  logic                  clk,
  input  logic                  nRST,
  regfile_exec_ctrl_if.master   bus,
  output logic                  done,
  output logic                  carry,
  output logic                  zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] instr_q;
  logic [3:0] a_q, b_q;
  logic [4:0] result;
  logic       accept;

  assign accept = (state == IDLE) && bus.instr_valid;

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept ? READ : IDLE;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded purely from state, so nothing combinational from instr_valid
  always_comb begin
    bus.instr_ready = (state == IDLE);
    bus.nWE         = (state != WRITE);
    done            = (state == WRITE);
  end

  // Bit 4 carries the ADD carry-out; for SUB the 5-bit wrap sets it iff A < B.
  always_comb begin
    result = 5'd0;
    case (instr_q[7:6])
      2'b00: result = {1'b0, a_q} + {1'b0, b_q};
      2'b01: result = {1'b0, a_q} - {1'b0, b_q};
      2'b10: result = {1'b0, a_q & b_q};
      2'b11: result = {1'b0, instr_q[3:0]};
      default: result = 5'd0;
    endcase
  end

  // Datapath registers. Read addresses are loaded at accept so they are
  // already valid throughout READ, and then simply hold.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      instr_q    <= 8'd0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      bus.A_addr <= 2'd0;
      bus.B_addr <= 2'd0;
      bus.D_addr <= 2'd0;
      bus.D_data <= 4'd0;
      carry      <= 1'b0;
      zero       <= 1'b0;
    end else begin
      if (accept) begin
        instr_q    <= bus.instr;
        bus.A_addr <= bus.instr[3:2];
        bus.B_addr <= bus.instr[1:0];
      end
      if (state == READ) begin
        a_q <= bus.A_data;
        b_q <= bus.B_data;
      end
      if (state == EXEC) begin
        bus.D_addr <= instr_q[5:4];
        bus.D_data <= result[3:0];
        carry      <= result[4];
        zero       <= (result[3:0] == 4'd0);
      end
    end
  end

endmodule

// File: tb/tb_regfile_exec_ctrl.sv
// Directed bench for regfile_exec_ctrl with a behavioural 4x4 register file.
// Expected values are hand-computed constants; the regfile model is not reset.
module tb_regfile_exec_ctrl;

  logic clk;
  logic nRST;
  logic done, carry, zero;
  int   total = 0;
  int   bad = 0;

  regfile_exec_ctrl_if ifc ();

  regfile_exec_ctrl dut (
    .clk   (clk),
    .nRST  (nRST),
    .bus   (ifc.master),
    .done  (done),
    .carry (carry),
    .zero  (zero)
  );

  // Register file model: combinational reads, write at rising edge when nWE=0
  logic [3:0] rf [4] = '{default: 4'd0};
  assign ifc.A_data = rf[ifc.A_addr];
  assign ifc.B_data = rf[ifc.B_addr];
  always @(posedge clk) begin
    if (!ifc.nWE) rf[ifc.D_addr] <= ifc.D_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ifc.instr_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ready_timeout"}, 32'(ifc.instr_ready), 32'd1);
  endtask

  // Issue one instruction and check READ addresses, the WRITE cycle and writeback
  task automatic run_instr(input string tag, input logic [7:0] ins,
                           input logic [1:0] ea, input logic [3:0] ed,
                           input logic ec, input logic ez);
    wait_ready(tag);
    ifc.instr = ins;
    ifc.instr_valid = 1'b1;
    step();                                   // READ
    ifc.instr_valid = 1'b0;
    chk({tag, "_ready_read"}, 32'(ifc.instr_ready), 32'd0);
    chk({tag, "_aaddr"}, 32'(ifc.A_addr), 32'(ins[3:2]));
    chk({tag, "_baddr"}, 32'(ifc.B_addr), 32'(ins[1:0]));
    step();                                   // EXEC
    chk({tag, "_nwe_exec"}, 32'(ifc.nWE), 32'd1);
    step();                                   // WRITE
    chk({tag, "_nwe"}, 32'(ifc.nWE), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_daddr"}, 32'(ifc.D_addr), 32'(ea));
    chk({tag, "_ddata"}, 32'(ifc.D_data), 32'(ed));
    chk({tag, "_carry"}, 32'(carry), 32'(ec));
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
    step();                                   // IDLE
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_carry_hold"}, 32'(carry), 32'(ec));
    chk({tag, "_rf"}, 32'(rf[ea]), 32'(ed));
  endtask

  logic [7:0] b2b [3];
  logic [3:0] b2b_res [3];
  int         dones;
  int         k;

  initial begin
    ifc.instr_valid = 1'b0;
    ifc.instr = 8'h00;
    nRST = 1'b0;
    #2;
    chk("rst_ready", 32'(ifc.instr_ready), 32'd1);
    chk("rst_nwe",   32'(ifc.nWE), 32'd1);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_aaddr", 32'(ifc.A_addr), 32'd0);
    chk("rst_baddr", 32'(ifc.B_addr), 32'd0);
    chk("rst_daddr", 32'(ifc.D_addr), 32'd0);
    chk("rst_ddata", 32'(ifc.D_data), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_zero",  32'(zero), 32'd0);
    #10 nRST = 1'b1;
    step();

    run_instr("ldi_r1",  8'b11_01_1010, 2'd1, 4'hA, 1'b0, 1'b0);
    run_instr("add_r2",  8'b00_10_01_01, 2'd2, 4'h4, 1'b1, 1'b0);
    run_instr("sub_r3z", 8'b01_11_01_01, 2'd3, 4'h0, 1'b0, 1'b1);
    run_instr("ldi_r0",  8'b11_00_0011, 2'd0, 4'h3, 1'b0, 1'b0);
    run_instr("ldi_r3",  8'b11_11_0101, 2'd3, 4'h5, 1'b0, 1'b0);
    run_instr("sub_brw", 8'b01_10_00_11, 2'd2, 4'hE, 1'b1, 1'b0);
    run_instr("and_r0",  8'b10_00_01_10, 2'd0, 4'hA, 1'b0, 1'b0);

    // Back-to-back with instr_valid held high: R0=1, R1=2, R2=R0+R1
    b2b[0] = 8'b11_00_0001; b2b_res[0] = 4'h1;
    b2b[1] = 8'b11_01_0010; b2b_res[1] = 4'h2;
    b2b[2] = 8'b00_10_00_01; b2b_res[2] = 4'h3;
    wait_ready("b2b");
    dones = 0;
    k = 0;
    ifc.instr = b2b[0];
    ifc.instr_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("b2b_ready_c%0d", c), 32'(ifc.instr_ready), 32'((c % 4) == 0));
      if (done) begin
        chk($sformatf("b2b_ddata_%0d", k), 32'(ifc.D_data), 32'(b2b_res[k]));
        dones++;
        k++;
      end
      if ((c % 4) == 1 && k < 2) ifc.instr = b2b[k + 1];
      if (c == 12) ifc.instr_valid = 1'b0;
    end
    chk("b2b_dones", 32'(dones), 32'd3);
    chk("b2b_r2", 32'(rf[2]), 32'd3);

    // Reset asserted in WRITE: no write lands, controller returns to IDLE
    wait_ready("rstw");
    ifc.instr = 8'b11_11_1001;
    ifc.instr_valid = 1'b1;
    step();
    ifc.instr_valid = 1'b0;
    step();
    step();
    chk("rstw_in_write", 32'(ifc.nWE), 32'd0);
    nRST = 1'b0;
    #1;
    chk("rstw_nwe",   32'(ifc.nWE), 32'd1);
    chk("rstw_done",  32'(done), 32'd0);
    chk("rstw_ready", 32'(ifc.instr_ready), 32'd1);
    chk("rstw_ddata", 32'(ifc.D_data), 32'd0);
    step();
    chk("rstw_r3_kept", 32'(rf[3]), 32'd5);
    nRST = 1'b1;
    run_instr("rstw_retry", 8'b11_11_1001, 2'd3, 4'h9, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
